// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// Optional back-pressure counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_buf #(
    parameter int unsigned DATA_W   = 192,
    parameter int unsigned EXC_W    = 5,
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EXC_PC   = 32'hbfc00380
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic [31:0]       in_badvaddr,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [31:0]       out_badvaddr,

    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cnt
);

    // Beat layout: {data, pc, exc, bd, badvaddr}
    localparam int unsigned BEAT_W = DATA_W + 32 + EXC_W + 1 + 32;

    localparam logic [BEAT_W-1:0] RESET_BEAT =
        {{DATA_W{1'b0}}, RESET_PC, {EXC_W{1'b0}}, 1'b0, 32'h0};
    localparam logic [BEAT_W-1:0] FLUSH_BEAT =
        {{DATA_W{1'b0}}, EXC_PC, {EXC_W{1'b0}}, 1'b0, 32'h0};

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [BEAT_W-1:0] main_q, main_d;
    logic [BEAT_W-1:0] skid_q, skid_d;
    logic [BEAT_W-1:0] in_beat;
    logic              accept;

    assign in_beat = {in_data, in_pc, in_exc, in_bd, in_badvaddr};
    assign accept  = in_valid & in_ready_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d       = FLUSH_BEAT;
            skid_d       = '0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // Skid is always older than any incoming beat.
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_beat;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_beat;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = in_beat;
        end
    end

    // Dedicated flop so in_ready has no combinational path from out_ready.
    assign in_ready_d = ~skid_valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_q       <= RESET_BEAT;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign {out_data, out_pc, out_exc, out_bd, out_badvaddr} = main_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = (main_valid_q && !out_ready) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: table-driven handshake rows with a beat scoreboard,
// plus hand-written async-reset and stall-counter sequences.
module tb_pipe_stage_buf;

    localparam int unsigned DATA_W   = 192;
    localparam int unsigned EXC_W    = 5;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_PC   = 32'hbfc00380;
`ifdef PIPE_STAGE_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd7;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
        logic [EXC_W-1:0]  exc;
        logic              bd;
        logic [31:0]       bva;
    } beat_t;

    // Stimulus for one cycle plus expected occupancy/in_ready after its edge.
    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [1:0] exp_occ;
        logic       exp_rdy;
    } row_t;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_pc;
    logic [EXC_W-1:0]  in_exc;
    logic              in_bd;
    logic [31:0]       in_badvaddr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_pc;
    logic [EXC_W-1:0]  out_exc;
    logic              out_bd;
    logic [31:0]       out_badvaddr;
    logic [1:0]        occupancy;
    logic [31:0]       stall_cnt;

    int    checks = 0;
    int    errors = 0;
    int    beat_n = 0;
    beat_t cur;
    beat_t hold;
    beat_t sb[$];
    logic  rdy_model;
    row_t  rows[21];

    pipe_stage_buf #(
        .DATA_W  (DATA_W),
        .EXC_W   (EXC_W),
        .RESET_PC(RESET_PC),
        .EXC_PC  (EXC_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_pc       (in_pc),
        .in_exc      (in_exc),
        .in_bd       (in_bd),
        .in_badvaddr (in_badvaddr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_pc      (out_pc),
        .out_exc     (out_exc),
        .out_bd      (out_bd),
        .out_badvaddr(out_badvaddr),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input string nm, input beat_t b);
        chk({nm, ".data"}, out_data, b.data);
        chk({nm, ".pc"}, {160'h0, out_pc}, {160'h0, b.pc});
        chk({nm, ".exc"}, {187'h0, out_exc}, {187'h0, b.exc});
        chk({nm, ".bd"}, {191'h0, out_bd}, {191'h0, b.bd});
        chk({nm, ".bva"}, {160'h0, out_badvaddr}, {160'h0, b.bva});
    endtask

    task automatic next_beat();
        cur.pc   = 32'h100 + 32'(4 * beat_n);
        cur.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cur.exc  = EXC_W'(beat_n + 1);
        cur.bd   = beat_n[0];
        cur.bva  = $urandom;
        beat_n++;
    endtask

    task automatic drive_beat();
        in_data     = cur.data;
        in_pc       = cur.pc;
        in_exc      = cur.exc;
        in_bd       = cur.bd;
        in_badvaddr = cur.bva;
    endtask

    task automatic run_row(input int idx, input row_t r);
        string nm;
        nm = $sformatf("row%0d", idx);
        in_valid  = r.iv;
        out_ready = r.ordy;
        flush     = r.fl;
        drive_beat();
        @(negedge clk);
        chk({nm, ".out_valid"}, {191'h0, out_valid}, {191'h0, (sb.size() != 0)});
        if (out_valid && r.ordy) begin
            if (sb.size() == 0) begin
                chk({nm, ".spurious_delivery"}, 192'h1, 192'h0);
            end else begin
                hold = sb.pop_front();
                chk_beat({nm, ".delivered"}, hold);
            end
        end
        if (r.iv && rdy_model) begin
            sb.push_back(cur);
            next_beat();
        end
        @(posedge clk);
        #1;
        if (r.fl) begin
            sb.delete();
            hold = '{data: '0, pc: EXC_PC, exc: '0, bd: 1'b0, bva: '0};
        end
        rdy_model = r.exp_rdy;
        chk({nm, ".occupancy"}, {190'h0, occupancy}, {190'h0, r.exp_occ});
        chk({nm, ".in_ready"}, {191'h0, in_ready}, {191'h0, r.exp_rdy});
        if (sb.size() != 0) chk_beat({nm, ".head"}, sb[0]);
        else                chk_beat({nm, ".held"}, hold);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        next_beat();
        drive_beat();
        rdy_model = 1'b1;
        hold = '{data: '0, pc: RESET_PC, exc: '0, bd: 1'b0, bva: '0};

        //           iv    ordy  fl    occ   rdy
        rows[0]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
        rows[1]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
        rows[2]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
        rows[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1};
        rows[4]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        rows[5]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
        rows[6]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
        rows[7]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
        rows[8]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
        rows[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1};
        rows[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        rows[11] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
        rows[12] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1};
        rows[13] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
        rows[14] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
        rows[15] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        rows[16] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
        rows[17] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        rows[18] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
        rows[19] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        rows[20] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst.out_pc", {160'h0, out_pc}, {160'h0, RESET_PC});
        chk("rst.out_valid", {191'h0, out_valid}, 192'h0);
        chk("rst.in_ready", {191'h0, in_ready}, 192'h1);
        chk("rst.occupancy", {190'h0, occupancy}, 192'h0);
        chk("rst.stall_cnt", {160'h0, stall_cnt}, 192'h0);

        for (int i = 0; i < 21; i++) begin
            run_row(i, rows[i]);
        end

        // Asynchronous reset while full, then reset+flush together
        in_valid  = 1'b1;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("areset.pre_occ", {190'h0, occupancy}, 192'h2);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("areset.out_valid", {191'h0, out_valid}, 192'h0);
        chk("areset.occupancy", {190'h0, occupancy}, 192'h0);
        chk("areset.in_ready", {191'h0, in_ready}, 192'h1);
        chk("areset.out_pc", {160'h0, out_pc}, {160'h0, RESET_PC});
        chk("areset.out_data", out_data, 192'h0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_flush.out_pc", {160'h0, out_pc}, {160'h0, RESET_PC});
        flush    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b0;

        // Back-pressure counter: 7 stalled cycles, then a flush leaves it alone
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("stall.out_valid", {191'h0, out_valid}, 192'h1);
        chk("stall.count", {160'h0, stall_cnt}, {160'h0, EXP_STALL});
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("stall.after_flush", {160'h0, stall_cnt}, {160'h0, EXP_STALL});
        chk("stall.flush_pc", {160'h0, out_pc}, {160'h0, EXC_PC});
        chk("stall.flush_valid", {191'h0, out_valid}, 192'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
